// File: rtl/adc_ser_ctrl_pkg.sv
// Shared types and defaults for the serial ADC front-end controller.
// State encodings and default sample/command widths used by adc_ser_ctrl.
package adc_ser_ctrl_pkg;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_CMD_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONV     = 3'd1,
        WAIT_INT = 3'd2,
        FRAME    = 3'd3,
        SHIFT    = 3'd4,
        DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/adc_ser_ctrl_if.sv
// ADC pin bundle: chip select, conversion start, end-of-conversion,
// serial clock, frame sync and both serial data lines.
interface adc_ser_ctrl_if;

    logic cs;
    logic cstart;
    logic int_n;
    logic sclk;
    logic fs;
    logic sdo;
    logic sdi;

    modport master (
        output cs, cstart, sclk, fs, sdo,
        input  int_n, sdi
    );

    modport slave (
        input  cs, cstart, sclk, fs, sdo,
        output int_n, sdi
    );

endinterface

// File: rtl/adc_sclk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV cycles while enabled and
// flags the cycle that drives sclk high (rise_t) or low (fall_t).
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_t,
    output logic fall_t
);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       sclk_q, sclk_d;
    logic       tick;

    always_comb begin
        tick      = en && (div_cnt_q == 8'(CLK_DIV - 1));
        rise_t    = tick && !sclk_q;
        fall_t    = tick && sclk_q;
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        // Disabled means parked low with the divider cleared, so the next
        // enable always starts a fresh low half-period.
        if (!en) begin
            div_cnt_d = '0;
            sclk_d    = 1'b0;
        end else if (tick) begin
            div_cnt_d = '0;
            sclk_d    = !sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/adc_ser_ctrl.sv
// Serial ADC channel controller: start pulse, end-of-conversion wait with
// timeout, framed MSB-first capture. ADC_AVG4_EN enables 4-sample averaging.
module adc_ser_ctrl
    import adc_ser_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CMD_W   = DEF_CMD_W,
    parameter int CST_LEN = 8,
    parameter int TMO     = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    adc_ser_ctrl_if.master    adc,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              err
);

    localparam int CST_W = $clog2(CST_LEN + 1);
    localparam int TMO_W = $clog2(TMO + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    state_e            state_q, state_d;
    logic              cs_q, cs_d;
    logic              cstart_q, cstart_d;
    logic              fs_q, fs_d;
    logic              sdo_q, sdo_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              dout_vld_q, dout_vld_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CST_W-1:0]  cst_cnt_q, cst_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              int_s1_q, int_s1_d;
    logic              int_s2_q, int_s2_d;
    logic              int_prev_q, int_prev_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, shreg_nxt;
    logic [CMD_W-1:0]  cmd_sr_q, cmd_sr_d, cmd_nxt;
    logic              int_fall;
    logic              sclk_en, sclk_w, rise_t, fall_t;

`ifdef ADC_AVG4_EN
    logic [1:0]        avg_cnt_q, avg_cnt_d;
    logic [DATA_W+1:0] acc_q, acc_d, acc_nxt;

    function automatic logic [DATA_W-1:0] avg4_trunc(input logic [DATA_W+1:0] sum);
        return DATA_W'(sum >> 2);
    endfunction
`endif

    assign sclk_en = (state_q == FRAME) || (state_q == SHIFT);

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (sclk_en),
        .sclk   (sclk_w),
        .rise_t (rise_t),
        .fall_t (fall_t)
    );

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        cstart_d   = cstart_q;
        fs_d       = fs_q;
        sdo_d      = sdo_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        dout_vld_d = 1'b0;
        dout_d     = dout_q;
        cst_cnt_d  = cst_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        cmd_sr_d   = cmd_sr_q;
        int_s1_d   = adc.int_n;
        int_s2_d   = int_s1_q;
        int_prev_d = int_s2_q;
        int_fall   = int_prev_q && !int_s2_q;
        shreg_nxt  = {shreg_q[DATA_W-2:0], adc.sdi};
        cmd_nxt    = cmd_sr_q << 1;
`ifdef ADC_AVG4_EN
        avg_cnt_d  = avg_cnt_q;
        acc_d      = acc_q;
        acc_nxt    = acc_q + {2'b00, shreg_nxt};
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_sr_d  = cmd;
                    busy_d    = 1'b1;
                    cstart_d  = 1'b0;
                    cst_cnt_d = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                if (cst_cnt_q == CST_W'(CST_LEN - 1)) begin
                    cstart_d  = 1'b1;
                    cst_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = WAIT_INT;
                end else begin
                    cst_cnt_d = cst_cnt_q + CST_W'(1);
                end
            end
            WAIT_INT: begin
                // The edge is tested first so it wins a same-cycle tie with the timeout.
                if (int_fall) begin
                    cs_d      = 1'b0;
                    fs_d      = 1'b1;
                    sdo_d     = cmd_sr_q[CMD_W-1];
                    tmo_cnt_d = '0;
                    state_d   = FRAME;
                end else if (tmo_cnt_q == TMO_W'(TMO - 1)) begin
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = IDLE;
`ifdef ADC_AVG4_EN
                    acc_d     = '0;
                    avg_cnt_d = '0;
`endif
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            FRAME: begin
                if (rise_t) begin
                    bit_cnt_d = BIT_W'(1);
                end
                if (fall_t) begin
                    fs_d     = 1'b0;
                    shreg_d  = shreg_nxt;
                    cmd_sr_d = cmd_nxt;
                    sdo_d    = cmd_nxt[CMD_W-1];
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_t) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
                if (fall_t) begin
                    shreg_d  = shreg_nxt;
                    cmd_sr_d = cmd_nxt;
                    sdo_d    = cmd_nxt[CMD_W-1];
                    // bit_cnt counts issued rising edges; this fall ends the last one.
                    if (bit_cnt_q == BIT_W'(DATA_W)) begin
                        cs_d      = 1'b1;
                        sdo_d     = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = DONE;
`ifdef ADC_AVG4_EN
                        if (avg_cnt_q == 2'd3) begin
                            dout_d     = avg4_trunc(acc_nxt);
                            dout_vld_d = 1'b1;
                            acc_d      = '0;
                            avg_cnt_d  = '0;
                        end else begin
                            acc_d     = acc_nxt;
                            avg_cnt_d = avg_cnt_q + 2'd1;
                        end
`else
                        dout_d     = shreg_nxt;
                        dout_vld_d = 1'b1;
`endif
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cs_q       <= 1'b1;
            cstart_q   <= 1'b1;
            fs_q       <= 1'b0;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
            cst_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            int_s1_q   <= 1'b1;
            int_s2_q   <= 1'b1;
            int_prev_q <= 1'b1;
`ifdef ADC_AVG4_EN
            avg_cnt_q  <= '0;
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            cstart_q   <= cstart_d;
            fs_q       <= fs_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            dout_vld_q <= dout_vld_d;
            dout_q     <= dout_d;
            cst_cnt_q  <= cst_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            int_s1_q   <= int_s1_d;
            int_s2_q   <= int_s2_d;
            int_prev_q <= int_prev_d;
`ifdef ADC_AVG4_EN
            avg_cnt_q  <= avg_cnt_d;
            acc_q      <= acc_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg_q  <= shreg_d;
        cmd_sr_q <= cmd_sr_d;
    end

    assign adc.cs     = cs_q;
    assign adc.cstart = cstart_q;
    assign adc.sclk   = sclk_w;
    assign adc.fs     = fs_q;
    assign adc.sdo    = sdo_q;
    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
